v_demux_stream: RTL and testbench
=================================

Name: v_demux_stream

Overview:
- 1-to-2 packet demultiplexer, the inverse of the team's 2:1 selector.
- One input stream with a valid/ready handshake is steered to output A or output B.
- The destination is chosen by Sel on the first beat of each packet and held until the packet's last beat.
- Each output has its own 2-entry buffer, so a stalled output never corrupts the other one.
- Sits between a shared producer and two independent consumers on the datapath.

Parameters:
W, 8, data width of input and output beats
CNT_W, 8, width of per-output packet counters

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  synchronous, active-high reset
Ent  input  W  input beat data
Ent_valid  input  1  input beat valid
Ent_last  input  1  marks final beat of packet
Ent_ready  output  1  block accepts the beat this cycle
Sel  input  1  destination select: 0 routes to A, 1 routes to B; sampled only on a packet's first beat
SalA  output  W  output A data
SalA_valid  output  1  output A beat valid
SalA_last  output  1  output A last marker
SalA_ready  input  1  consumer A accepts
SalB  output  W  output B data
SalB_valid  output  1  output B beat valid
SalB_last  output  1  output B last marker
SalB_ready  input  1  consumer B accepts
PktA_cnt  output  CNT_W  packets accepted toward A
PktB_cnt  output  CNT_W  packets accepted toward B
busy  output  1  a packet is in progress (FSM not in IDLE)

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: FSM in IDLE; both buffers empty; SalA/SalB = 0; all valid and last outputs = 0; counters = 0; busy = 0. Ent_ready = 0 while rst is high.
- Handshake: a beat transfers on any edge where valid && ready. Data, last and valid are held stable until accepted.
- Upstream rule: Ent_valid must not drop without acceptance. The block never relies on it dropping.
- FSM states:
  - IDLE: target = Sel (combinational). On accept with Ent_last=1, stay in IDLE (single-beat packet). On accept with Ent_last=0, go to TO_A if Sel=0, else TO_B.
  - TO_A / TO_B: Sel is ignored and the target is fixed. On accept with Ent_last=1, return to IDLE. Otherwise stay.
- Ent_ready = !full of the target buffer. There is no combinational path from SalX_ready to Ent_ready.
- Buffer:
  - 2-entry FIFO per output, storing {data, last}; output is registered.
  - Latency: a beat accepted at edge N is presented on SalX_valid from edge N, i.e. visible in the cycle after acceptance.
  - Throughput: sustained 1 beat/cycle per output while SalX_ready=1.
  - Push and pop in the same cycle are legal when occupancy is 1; occupancy stays 1.
  - When full, no push occurs because Ent_ready=0. Pop when full frees one slot, and Ent_ready rises the next cycle.
- Counters: PktX_cnt increments by 1 on accept of a beat with Ent_last=1 routed to X. Counters wrap modulo 2^CNT_W (255 to 0 at default).
- A stall on the non-target output has no effect on Ent_ready.
- Sel changing mid-packet is ignored. Sel changing in IDLE with Ent_valid high and no accept takes effect immediately, because routing is evaluated per cycle.
- Reset mid-packet: FSM returns to IDLE and buffers are flushed. Beats not yet presented are dropped; a partial packet may have been delivered. Counters clear.
- Zero-length packets do not exist; every packet has at least one beat.

Decomposition:
- Shared package v_demux_pkg:
  - state enum {IDLE, TO_A, TO_B};
  - localparam DEST_A = 1'b0, DEST_B = 1'b1;
  - beat struct {data[W], last}.
- One natural sub-module, v_demux_slot: 2-entry registered FIFO with push/pop, full/empty, instantiated once per output.
- The top level holds the FSM, routing and counters.

Test Plan:
- Reset then single-beat packet Ent=0x3C, last=1, Sel=0 -> SalA=0x3C, SalA_last=1 one cycle later; PktA_cnt=1; SalB_valid stays 0.
- 4-beat packet 0x10..0x13 with Sel=1 on beat 1 and Sel toggling each later beat -> all 4 beats on B in order; PktB_cnt=1; busy high from beat 2 until last accepted.
- SalA_ready=0, stream 3 beats to A -> 2 accepted, Ent_ready=0 on the third. Raise SalA_ready -> Ent_ready=1 the next cycle, and all 3 beats exit in order.
- A stalled, packet to B -> B traffic flows at 1 beat/cycle; Ent_ready is unaffected by A.
- Back-to-back single-beat packets alternating Sel=0/1 for 256 packets per side -> both counters wrap to 0; no lost or misrouted beats.
- Assert rst in the middle of a 5-beat packet after beat 2 -> next cycle all valid=0, counters=0, busy=0. The following packet with Sel=0 routes to A normally.

Source files
------------

// File: rtl/v_demux_pkg.sv
// Shared types for the 1-to-2 packet demultiplexer: FSM states, destination codes,
// the stored beat layout and the routing rule.
package v_demux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TO_A = 2'd1,
    TO_B = 2'd2
  } state_t;

  localparam logic DEST_A = 1'b0;
  localparam logic DEST_B = 1'b1;

  localparam int BEAT_W = 8;

  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic              last;
  } beat_t;

  // Sel only matters between packets; mid-packet the destination is locked by the state.
  function automatic logic route(input state_t st, input logic sel);
    case (st)
      IDLE:    return sel;
      TO_B:    return DEST_B;
      default: return DEST_A;
    endcase
  endfunction

endpackage

// File: rtl/v_demux_slot.sv
// Two-entry FIFO with a registered head; a pushed beat is visible on dout the cycle after
// the push edge, and push+pop at occupancy 1 sustains one beat per cycle.
module v_demux_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  input  logic         pop_ready,
  output logic [W-1:0] dout,
  output logic         dout_last,
  output logic         dout_valid,
  output logic         full
);

  logic [W:0] head_reg;
  logic [W:0] tail_reg;
  logic [1:0] count_reg;
  logic       do_push;
  logic       do_pop;

  assign full       = (count_reg == 2'd2);
  assign dout_valid = (count_reg != 2'd0);
  assign dout       = head_reg[W-1:0];
  assign dout_last  = head_reg[W];

  assign do_pop  = dout_valid && pop_ready;
  assign do_push = push && !full;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_reg == 2'd0) head_reg <= {push_last, push_data};
          else                   tail_reg <= {push_last, push_data};
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          if (count_reg == 2'd2) head_reg <= tail_reg;
          count_reg <= count_reg - 2'd1;
        end
        // Only reachable at occupancy 1: the departing head is replaced in place.
        2'b11: head_reg <= {push_last, push_data};
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/v_demux_stream.sv
// 1-to-2 packet demultiplexer: the first beat's Sel picks A or B, the packet stays on that
// output until its last beat, and each output drains through its own two-entry slot.
module v_demux_stream
  import v_demux_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     Ent,
  input  logic             Ent_valid,
  input  logic             Ent_last,
  output logic             Ent_ready,
  input  logic             Sel,
  output logic [W-1:0]     SalA,
  output logic             SalA_valid,
  output logic             SalA_last,
  input  logic             SalA_ready,
  output logic [W-1:0]     SalB,
  output logic             SalB_valid,
  output logic             SalB_last,
  input  logic             SalB_ready,
  output logic [CNT_W-1:0] PktA_cnt,
  output logic [CNT_W-1:0] PktB_cnt,
  output logic             busy
);

  state_t           state_reg;
  state_t           state_next;
  logic             target;
  logic             accept;
  logic [1:0]       push_vec;
  logic [1:0]       full_vec;
  logic [1:0]       valid_vec;
  logic [1:0]       last_vec;
  logic [1:0]       ready_vec;
  logic [W-1:0]     data_vec [2];
  logic [CNT_W-1:0] cnt_vec  [2];

  assign target    = route(state_reg, Sel);
  // Readiness depends only on registered slot occupancy, never on the consumers' ready.
  assign Ent_ready = !rst && !full_vec[target];
  assign accept    = Ent_valid && Ent_ready;
  assign busy      = (state_reg != IDLE);
  assign ready_vec = {SalB_ready, SalA_ready};

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:       if (accept && !Ent_last) state_next = (Sel == DEST_A) ? TO_A : TO_B;
      TO_A, TO_B: if (accept && Ent_last)  state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_out
      logic [CNT_W-1:0] cnt_reg;

      assign push_vec[gi] = accept && (target == ((gi == 1) ? DEST_B : DEST_A));

      v_demux_slot #(.W(W)) u_slot (
        .clk        (clk),
        .rst        (rst),
        .push       (push_vec[gi]),
        .push_data  (Ent),
        .push_last  (Ent_last),
        .pop_ready  (ready_vec[gi]),
        .dout       (data_vec[gi]),
        .dout_last  (last_vec[gi]),
        .dout_valid (valid_vec[gi]),
        .full       (full_vec[gi])
      );

      always_ff @(posedge clk) begin
        if (rst)                          cnt_reg <= '0;
        else if (push_vec[gi] && Ent_last) cnt_reg <= cnt_reg + 1'b1;
      end

      assign cnt_vec[gi] = cnt_reg;
    end
  endgenerate

  assign SalA       = data_vec[0];
  assign SalA_last  = last_vec[0];
  assign SalA_valid = valid_vec[0];
  assign SalB       = data_vec[1];
  assign SalB_last  = last_vec[1];
  assign SalB_valid = valid_vec[1];
  assign PktA_cnt   = cnt_vec[0];
  assign PktB_cnt   = cnt_vec[1];

endmodule

// File: tb/tb_v_demux_stream.sv
// Bench for v_demux_stream: per-output queues of in-flight beats act as the reference;
// table-driven single-beat routing, hand-written stall/reset sequences and random traffic.
module tb_v_demux_stream;

  localparam int W     = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [W-1:0]     Ent = '0;
  logic             Ent_valid = 1'b0;
  logic             Ent_last = 1'b0;
  logic             Ent_ready;
  logic             Sel = 1'b0;
  logic [W-1:0]     SalA;
  logic             SalA_valid;
  logic             SalA_last;
  logic             SalA_ready = 1'b1;
  logic [W-1:0]     SalB;
  logic             SalB_valid;
  logic             SalB_last;
  logic             SalB_ready = 1'b1;
  logic [CNT_W-1:0] PktA_cnt;
  logic [CNT_W-1:0] PktB_cnt;
  logic             busy;

  always #5 clk = ~clk;

  v_demux_stream #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .Ent        (Ent),
    .Ent_valid  (Ent_valid),
    .Ent_last   (Ent_last),
    .Ent_ready  (Ent_ready),
    .Sel        (Sel),
    .SalA       (SalA),
    .SalA_valid (SalA_valid),
    .SalA_last  (SalA_last),
    .SalA_ready (SalA_ready),
    .SalB       (SalB),
    .SalB_valid (SalB_valid),
    .SalB_last  (SalB_last),
    .SalB_ready (SalB_ready),
    .PktA_cnt   (PktA_cnt),
    .PktB_cnt   (PktB_cnt),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference: beats accepted but not yet taken by each consumer, {last, data}.
  logic [W:0] qa[$];
  logic [W:0] qb[$];
  int cnt_a = 0;
  int cnt_b = 0;
  bit in_pkt = 1'b0;
  bit pkt_dest = 1'b0;
  bit last_acc = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_target();
    return in_pkt ? pkt_dest : Sel;
  endfunction

  function automatic bit model_ready();
    if (rst) return 1'b0;
    return model_target() ? (qb.size() < 2) : (qa.size() < 2);
  endfunction

  // One clock: check outputs against the model, take the edge, advance the model.
  task automatic tick();
    bit acc, pa, pb, tgt;
    #1;
    chk("ent_ready", Ent_ready, model_ready());
    chk("a_valid", SalA_valid, qa.size() != 0);
    chk("b_valid", SalB_valid, qb.size() != 0);
    if (qa.size() != 0) begin
      chk("a_data", SalA, qa[0][W-1:0]);
      chk("a_last", SalA_last, qa[0][W]);
    end
    if (qb.size() != 0) begin
      chk("b_data", SalB, qb[0][W-1:0]);
      chk("b_last", SalB_last, qb[0][W]);
    end
    tgt = model_target();
    acc = Ent_valid && model_ready();
    pa  = (qa.size() != 0) && SalA_ready;
    pb  = (qb.size() != 0) && SalB_ready;
    @(posedge clk);
    if (rst) begin
      qa.delete();
      qb.delete();
      cnt_a = 0;
      cnt_b = 0;
      in_pkt = 1'b0;
      last_acc = 1'b0;
    end else begin
      if (pa) void'(qa.pop_front());
      if (pb) void'(qb.pop_front());
      if (acc) begin
        if (tgt) qb.push_back({Ent_last, Ent});
        else     qa.push_back({Ent_last, Ent});
        if (Ent_last) begin
          in_pkt = 1'b0;
          if (tgt) cnt_b++;
          else     cnt_a++;
        end else begin
          in_pkt = 1'b1;
          pkt_dest = tgt;
        end
      end
      last_acc = acc;
    end
    #1;
    chk("pkt_a_cnt", PktA_cnt, cnt_a % (1 << CNT_W));
    chk("pkt_b_cnt", PktB_cnt, cnt_b % (1 << CNT_W));
    chk("busy", busy, in_pkt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    Ent_valid = 1'b0;
    SalA_ready = 1'b1;
    SalB_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit         sel;
    logic [W-1:0] data;
    bit         exp_a;
    bit         exp_b;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 8'hA5, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h81, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h7E, 1'b0, 1'b1};

    // Reset state, with a beat already offered while rst is high.
    rst = 1'b1;
    Ent_valid = 1'b1;
    Ent = 8'h99;
    Ent_last = 1'b1;
    tick();
    #1;
    chk("rst_ent_ready", Ent_ready, 0);
    chk("rst_sala", SalA, 0);
    chk("rst_salb", SalB, 0);
    chk("rst_sala_last", SalA_last, 0);
    chk("rst_salb_last", SalB_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt_a", PktA_cnt, 0);
    Ent_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Single-beat packets from the table, both consumers ready.
    for (int i = 0; i < 6; i++) begin
      Ent = vecs[i].data;
      Ent_last = 1'b1;
      Ent_valid = 1'b1;
      Sel = vecs[i].sel;
      tick();
      Ent_valid = 1'b0;
      chk("tbl_a_valid", SalA_valid, vecs[i].exp_a);
      chk("tbl_b_valid", SalB_valid, vecs[i].exp_b);
      chk("tbl_data", vecs[i].exp_a ? SalA : SalB, vecs[i].data);
      chk("tbl_last", vecs[i].exp_a ? SalA_last : SalB_last, 1);
      if (i == 0) chk("tbl_first_cnt_a", PktA_cnt, 1);
      $display("vec %0d: sel=%0d data=%02h -> A_valid=%0d B_valid=%0d", i, vecs[i].sel,
               vecs[i].data, SalA_valid, SalB_valid);
      tick();
    end

    // Four-beat packet to B while Sel toggles after the first beat.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      Ent = W'(8'h10 + i);
      Ent_last = (i == 3);
      Sel = (i % 2 == 0);
      Ent_valid = 1'b1;
      tick();
      chk("b4_data", SalB, 8'h10 + i);
      chk("b4_valid", SalB_valid, 1);
      chk("b4_a_idle", SalA_valid, 0);
      chk("b4_busy", busy, i < 3);
    end
    Ent_valid = 1'b0;
    tick();
    chk("b4_cnt_b", PktB_cnt, 1);
    $display("seq b4: 4 beats to B, PktB_cnt=%0d", PktB_cnt);

    // Consumer A stalled: two beats fill the slot, the third waits.
    do_reset();
    SalA_ready = 1'b0;
    Sel = 1'b0;
    Ent_valid = 1'b1;
    Ent_last = 1'b0;
    Ent = 8'h20;
    tick();
    Ent = 8'h21;
    tick();
    Ent = 8'h22;
    Ent_last = 1'b1;
    #1;
    chk("stall_ready_full", Ent_ready, 0);
    tick();
    chk("stall_still_full", Ent_ready, 0);
    chk("stall_head", SalA, 8'h20);
    SalA_ready = 1'b1;
    #1;
    chk("stall_no_comb_path", Ent_ready, 0);
    tick();
    chk("stall_ready_back", Ent_ready, 1);
    chk("stall_second", SalA, 8'h21);
    tick();
    chk("stall_third", SalA, 8'h22);
    chk("stall_third_last", SalA_last, 1);
    Ent_valid = 1'b0;
    tick();
    chk("stall_drained", SalA_valid, 0);
    chk("stall_cnt_a", PktA_cnt, 1);
    $display("seq stall: 3 beats to A through a stalled consumer");

    // A full and stalled; a packet to B still flows at one beat per cycle.
    do_reset();
    SalA_ready = 1'b0;
    Sel = 1'b0;
    Ent_last = 1'b1;
    Ent_valid = 1'b1;
    Ent = 8'h30;
    tick();
    Ent = 8'h31;
    tick();
    Sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Ent = W'(8'h40 + i);
      Ent_last = (i == 2);
      #1;
      chk("bflow_ready", Ent_ready, 1);
      tick();
      chk("bflow_data", SalB, 8'h40 + i);
    end
    Ent_valid = 1'b0;
    Sel = 1'b0;
    #1;
    chk("idle_sel_a_full", Ent_ready, 0);
    Sel = 1'b1;
    #1;
    chk("idle_sel_b_free", Ent_ready, 1);
    SalA_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    $display("seq bflow: B packet passed A stall");

    // Counter wrap: 256 single-beat packets per side, alternating.
    do_reset();
    Ent_valid = 1'b1;
    Ent_last = 1'b1;
    for (int i = 0; i < 512; i++) begin
      Sel = i[0];
      Ent = W'(i * 7 + 3);
      tick();
    end
    Ent_valid = 1'b0;
    tick();
    tick();
    chk("wrap_cnt_a", PktA_cnt, 0);
    chk("wrap_cnt_b", PktB_cnt, 0);
    $display("seq wrap: 512 packets, PktA_cnt=%0d PktB_cnt=%0d", PktA_cnt, PktB_cnt);

    // Reset in the middle of a five-beat packet.
    do_reset();
    Sel = 1'b0;
    Ent = 8'h4F;
    Ent_last = 1'b1;
    Ent_valid = 1'b1;
    tick();
    SalB_ready = 1'b0;
    Sel = 1'b1;
    Ent_last = 1'b0;
    Ent = 8'h50;
    tick();
    Ent = 8'h51;
    tick();
    rst = 1'b1;
    Ent_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrst_a_valid", SalA_valid, 0);
    chk("midrst_b_valid", SalB_valid, 0);
    chk("midrst_cnt_a", PktA_cnt, 0);
    chk("midrst_cnt_b", PktB_cnt, 0);
    chk("midrst_busy", busy, 0);
    SalB_ready = 1'b1;
    Sel = 1'b0;
    Ent = 8'h60;
    Ent_last = 1'b1;
    Ent_valid = 1'b1;
    tick();
    Ent_valid = 1'b0;
    chk("midrst_next_a", SalA, 8'h60);
    chk("midrst_next_valid", SalA_valid, 1);
    chk("midrst_next_cnt", PktA_cnt, 1);
    tick();
    $display("seq midrst: packet after reset routed to A");

    // Random traffic against the reference, with occasional resets.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (!Ent_valid || last_acc) begin
        Ent_valid = ($urandom_range(3) != 0);
        Ent = W'($urandom);
        Ent_last = ($urandom_range(2) == 0);
      end
      Sel = ($urandom_range(1) != 0);
      SalA_ready = ($urandom_range(3) != 0);
      SalB_ready = ($urandom_range(4) == 0) ? 1'b0 : 1'b1;
      rst = (c % 997 == 996);
      tick();
    end
    rst = 1'b0;
    Ent_valid = 1'b0;
    SalA_ready = 1'b1;
    SalB_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    $display("seq random: PktA_cnt=%0d PktB_cnt=%0d", PktA_cnt, PktB_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
